mult_accumulator: RTL and testbench

- Stage directly downstream of the pipelined multiplier in the PE datapath.
- Consumes the multiplier's product/valid stream and sums groups of ACC_LEN consecutive valid products into one dot-product result.
- Completed sums go through a 2-entry output buffer with a valid/ready handshake toward the write-back stage.
- The multiplier cannot stall, so the input side has no backpressure; a sum that finds the buffer full is dropped and flagged.

---
 rtl/mult_accumulator.sv | 146 ++++++++++++++
 tb/tb_mult_accumulator.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - groups consecutive valid products into dot-product sums behind a 2-entry output buffer
module mult_accumulator #(
    parameter int WIDTH_IN    = 48,
    parameter int WIDTH_OUT   = 64,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [WIDTH_IN-1:0]    IN_DATA,
    input  logic                   IN_VALID,
    input  logic [COUNT_WIDTH-1:0] ACC_LEN,
    input  logic                   CLEAR,
    output logic [WIDTH_OUT-1:0]   OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   BUSY,
    output logic                   OVERFLOW
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state, state_next;
    logic [WIDTH_OUT-1:0]   acc, acc_next;
    logic [COUNT_WIDTH-1:0] cnt, cnt_next;
    logic [COUNT_WIDTH-1:0] len, len_next;
    logic [WIDTH_OUT-1:0]   in_ext;
    logic [WIDTH_OUT-1:0]   sum;
    logic [COUNT_WIDTH-1:0] cnt_inc;
    logic [COUNT_WIDTH-1:0] first_len;
    logic                   push;
    logic [WIDTH_OUT-1:0]   push_data;

    logic [WIDTH_OUT-1:0]   head, tail;
    logic [1:0]             fill;
    logic                   ovf;
    logic                   pop;

    assign in_ext    = WIDTH_OUT'(IN_DATA);
    assign sum       = acc + in_ext;
    assign cnt_inc   = cnt + COUNT_WIDTH'(1);
    // A zero group length is treated as a group of one product.
    assign first_len = (ACC_LEN == '0) ? COUNT_WIDTH'(1) : ACC_LEN;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            len   <= len_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        len_next   = len;
        push       = 1'b0;
        push_data  = sum;
        if (CLEAR) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
        end else if (IN_VALID) begin
            case (state)
                IDLE: begin
                    len_next  = first_len;
                    acc_next  = in_ext;
                    cnt_next  = COUNT_WIDTH'(1);
                    push_data = in_ext;
                    if (first_len == COUNT_WIDTH'(1)) begin
                        push = 1'b1;
                    end else begin
                        state_next = ACCUM;
                    end
                end
                ACCUM: begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == len) begin
                        push       = 1'b1;
                        acc_next   = '0;
                        state_next = IDLE;
                    end else begin
                        acc_next = sum;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign pop = (fill != 2'd0) && OUT_READY;

    // Shift-style buffer: head is always the oldest entry and drives OUT_DATA directly.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            head <= '0;
            tail <= '0;
            fill <= 2'd0;
            ovf  <= 1'b0;
        end else begin
            case (fill)
                2'd0: begin
                    if (push) begin
                        head <= push_data;
                        fill <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && push) begin
                        head <= push_data;
                    end else if (pop) begin
                        fill <= 2'd0;
                    end else if (push) begin
                        tail <= push_data;
                        fill <= 2'd2;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= push_data;
                        end else begin
                            fill <= 2'd1;
                        end
                    end else if (push) begin
                        ovf <= 1'b1;
                    end
                end
                default: fill <= 2'd0;
            endcase
        end
    end

    assign OUT_DATA  = head;
    assign OUT_VALID = (fill != 2'd0);
    assign BUSY      = (state == ACCUM);
    assign OVERFLOW  = ovf;

endmodule

// File: tb/tb_mult_accumulator.sv
// tb/tb_mult_accumulator.sv - randomized and directed bench for mult_accumulator against a group/queue reference model
module tb_mult_accumulator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [47:0] IN_DATA = '0;
    logic        IN_VALID = 1'b0;
    logic [15:0] ACC_LEN = '0;
    logic        CLEAR = 1'b0;
    logic        OUT_READY = 1'b0;
    logic [63:0] OUT_DATA;
    logic        OUT_VALID;
    logic        BUSY;
    logic        OVERFLOW;
    logic [47:0] o48_data;
    logic        o48_valid;
    logic        o48_busy;
    logic        o48_ovf;

    int ncmp = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    mult_accumulator dut (
        .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .ACC_LEN(ACC_LEN), .CLEAR(CLEAR), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .BUSY(BUSY), .OVERFLOW(OVERFLOW)
    );

    mult_accumulator #(.WIDTH_IN(48), .WIDTH_OUT(48), .COUNT_WIDTH(16)) dut48 (
        .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .ACC_LEN(ACC_LEN), .CLEAR(CLEAR), .OUT_DATA(o48_data), .OUT_VALID(o48_valid),
        .OUT_READY(OUT_READY), .BUSY(o48_busy), .OVERFLOW(o48_ovf)
    );

    // Reference model: an open group (length, running sum, count) and a queue of finished sums.
    logic [63:0] exp_q[$];
    bit          g_active;
    int          g_len;
    int          g_cnt;
    logic [63:0] g_sum;
    bit          m_ovf;

    function automatic logic [66:0] model_vec();
        return {exp_q.size() > 0, g_active, m_ovf, (exp_q.size() > 0) ? exp_q[0] : 64'd0};
    endfunction

    function automatic logic [66:0] dut_vec();
        return {OUT_VALID, BUSY, OVERFLOW, OUT_VALID ? OUT_DATA : 64'd0};
    endfunction

    task automatic do_reset();
        RESET = 1'b0;
        IN_VALID = 1'b0;
        CLEAR = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        exp_q.delete();
        g_active = 0;
        g_cnt = 0;
        g_sum = '0;
        m_ovf = 0;
    endtask

    task automatic cycle(input bit v, input logic [47:0] d, input logic [15:0] len,
                         input bit clr, input bit rdy);
        bit          pop;
        bit          done;
        IN_VALID  = v;
        IN_DATA   = d;
        ACC_LEN   = len;
        CLEAR     = clr;
        OUT_READY = rdy;
        pop  = (exp_q.size() > 0) && rdy;
        done = 0;
        if (clr) begin
            g_active = 0;
        end else if (v) begin
            if (!g_active) begin
                g_active = 1;
                g_len = (len == 0) ? 1 : int'(len);
                g_cnt = 0;
                g_sum = '0;
            end
            g_sum = g_sum + {16'd0, d};
            g_cnt++;
            if (g_cnt == g_len) begin
                done = 1;
                g_active = 0;
            end
        end
        if (pop) void'(exp_q.pop_front());
        if (done) begin
            if (exp_q.size() < 2) exp_q.push_back(g_sum);
            else m_ovf = 1;
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        CLEAR = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ncmp++;
        if ({OUT_VALID, BUSY, OVERFLOW, OUT_DATA} !== 67'd0) begin
            nerr++;
            $display("FAIL reset got %h exp %h", {OUT_VALID, BUSY, OVERFLOW, OUT_DATA}, 67'd0);
        end
    endtask

    task automatic test_basic();
        logic [47:0] prods[4];
        int busy_cnt;
        prods = '{48'd3, 48'd5, 48'd7, 48'd9};
        busy_cnt = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) cycle(1, prods[i], 16'd4, 0, 1);
            else cycle(0, '0, 16'd4, 0, 1);
            if (BUSY) busy_cnt++;
            ncmp++;
            if (dut_vec() !== model_vec()) begin
                nerr++;
                $display("FAIL basic cyc%0d got %h exp %h", i, dut_vec(), model_vec());
            end
            if (i == 3) begin
                ncmp++;
                if (OUT_VALID !== 1'b1 || OUT_DATA !== 64'd24) begin
                    nerr++;
                    $display("FAIL basic_sum got %0b/%0d exp 1/24", OUT_VALID, OUT_DATA);
                end
            end
        end
        ncmp++;
        if (busy_cnt != 3) begin
            nerr++;
            $display("FAIL basic_busy got %0d exp 3", busy_cnt);
        end
    endtask

    task automatic test_len_one();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1, 48'hFFFF_FFFF_FFFF, 16'(i), 0, 1);
            ncmp++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== 64'h0000_FFFF_FFFF_FFFF || BUSY !== 1'b0) begin
                nerr++;
                $display("FAIL len_one len%0d got %0b/%h/%0b exp 1/0000ffffffffffff/0",
                         i, OUT_VALID, OUT_DATA, BUSY);
            end
            cycle(0, '0, 16'(i), 0, 1);
            ncmp++;
            if (dut_vec() !== model_vec()) begin
                nerr++;
                $display("FAIL len_one_idle len%0d got %h exp %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] p;
        logic [63:0] full;
        logic [47:0] exp48;
        p = 64'd1 << 47;
        full = 3 * p;
        exp48 = full[47:0];
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle((i % 3) == 0, p[47:0], 16'd3, 0, 1);
            ncmp++;
            if (dut_vec() !== model_vec()) begin
                nerr++;
                $display("FAIL wrap cyc%0d got %h exp %h", i, dut_vec(), model_vec());
            end
            if (i == 6) begin
                ncmp++;
                if (o48_valid !== 1'b1 || o48_data !== exp48 || o48_busy !== 1'b0 || o48_ovf !== 1'b0) begin
                    nerr++;
                    $display("FAIL wrap48 got %0b/%h/%0b/%0b exp 1/%h/0/0",
                             o48_valid, o48_data, o48_busy, o48_ovf, exp48);
                end
                ncmp++;
                if (OUT_DATA !== full) begin
                    nerr++;
                    $display("FAIL wrap64 got %h exp %h", OUT_DATA, full);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            for (int j = 0; j < 2; j++) begin
                cycle(1, 48'(k), 16'd2, 0, 0);
                ncmp++;
                if (dut_vec() !== model_vec()) begin
                    nerr++;
                    $display("FAIL ovf_fill k%0d got %h exp %h", k, dut_vec(), model_vec());
                end
            end
        end
        ncmp++;
        if (OVERFLOW !== 1'b1 || OUT_DATA !== 64'd2) begin
            nerr++;
            $display("FAIL ovf_flag got %0b/%0d exp 1/2", OVERFLOW, OUT_DATA);
        end
        cycle(0, '0, 16'd2, 0, 1);
        ncmp++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 64'd4) begin
            nerr++;
            $display("FAIL ovf_pop1 got %0b/%0d exp 1/4", OUT_VALID, OUT_DATA);
        end
        cycle(0, '0, 16'd2, 0, 1);
        ncmp++;
        if (OUT_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_pop2 got %0b/%0b exp 0/1", OUT_VALID, OVERFLOW);
        end
    endtask

    task automatic test_clear();
        do_reset();
        cycle(1, 48'd7, 16'd1, 0, 0);
        cycle(1, 48'd1, 16'd4, 0, 0);
        cycle(1, 48'd1, 16'd4, 0, 0);
        cycle(1, 48'd9, 16'd4, 1, 0);
        ncmp++;
        if (dut_vec() !== model_vec()) begin
            nerr++;
            $display("FAIL clear_now got %h exp %h", dut_vec(), model_vec());
        end
        for (int i = 0; i < 4; i++) cycle(1, 48'd1, 16'd4, 0, 0);
        ncmp++;
        if (OUT_DATA !== 64'd7 || OUT_VALID !== 1'b1 || OVERFLOW !== 1'b0) begin
            nerr++;
            $display("FAIL clear_keep got %0d/%0b/%0b exp 7/1/0", OUT_DATA, OUT_VALID, OVERFLOW);
        end
        cycle(0, '0, 16'd4, 0, 1);
        ncmp++;
        if (OUT_DATA !== 64'd4 || OUT_VALID !== 1'b1) begin
            nerr++;
            $display("FAIL clear_sum got %0d/%0b exp 4/1", OUT_DATA, OUT_VALID);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1, 48'd7, 16'd1, 0, 0);
        cycle(1, 48'd3, 16'd4, 0, 0);
        cycle(1, 48'd3, 16'd1, 0, 0);
        do_reset();
        ncmp++;
        if ({OUT_VALID, BUSY, OVERFLOW, OUT_DATA} !== 67'd0) begin
            nerr++;
            $display("FAIL reset_mid got %h exp 0", {OUT_VALID, BUSY, OVERFLOW, OUT_DATA});
        end
        cycle(1, 48'd5, 16'd2, 0, 1);
        cycle(1, 48'd6, 16'd2, 0, 1);
        ncmp++;
        if (OUT_DATA !== 64'd11 || OUT_VALID !== 1'b1 || BUSY !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_sum got %0d/%0b/%0b exp 11/1/0", OUT_DATA, OUT_VALID, BUSY);
        end
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [47:0] d;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = {$urandom(), $urandom()};
            d = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF : r[47:0];
            cycle($urandom_range(0, 9) < 7, d, 16'($urandom_range(0, 5)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 5);
            ncmp++;
            if (dut_vec() !== model_vec()) begin
                nerr++;
                $display("FAIL random cyc%0d got %h exp %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_one();
        test_wrap();
        test_overflow();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
